shift_register: RTL and testbench

SHIFT_REGISTER -- requirements
Module: shift_register

---
 rtl/shift_register_pkg.sv | 14 +
 rtl/shift_register.sv | 50 +++++
 tb/tb_shift_register.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
// Shared constants and helpers for the serial-to-parallel shift register.
// Import wherever a count port width has to be derived from WIDTH.
package shift_register_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 32;

    // Bits needed to hold a saturating count of 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_register.sv
// Serial-in / parallel-out shift register with a saturating fill counter.
// Shifts unconditionally on every rising clk edge; gate clk to pause shifting.
module shift_register
    import shift_register_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in,
    output logic [WIDTH-1:0]               data,
    output logic [count_width(WIDTH)-1:0]  count,
    output logic                           full
);

    localparam int                CW         = count_width(WIDTH);
    localparam logic [CW-1:0]     FULL_COUNT = CW'(WIDTH);

    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_count;
    logic             w_full;

    // The oldest bit falls off the far end; nothing flags the loss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (MSB_FIRST != 0) begin
            r_data <= {r_data[WIDTH-2:0], in};
        end else begin
            r_data <= {in, r_data[WIDTH-1:1]};
        end
    end

    // Counter never looks at in, so an unknown serial bit cannot corrupt it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_count != FULL_COUNT) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign w_full = (r_count == FULL_COUNT);

    assign data  = r_data;
    assign count = r_count;
    assign full  = w_full;

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench: three shift_register instances on a shared clock,
// compared against a bit-history model of what each should hold.
module tb_shift_register;

    logic        clk;
    logic        rst;
    logic        tb_in;

    logic [11:0] d_m12;
    logic [3:0]  c_m12;
    logic        f_m12;
    logic [11:0] d_l12;
    logic [3:0]  c_l12;
    logic        f_l12;
    logic [3:0]  d_m4;
    logic [2:0]  c_m4;
    logic        f_m4;

    int n_cmp = 0;
    int n_err = 0;

    // Every bit accepted since the last reset, oldest first.
    logic hist[$];

    shift_register #(.WIDTH(12), .MSB_FIRST(1)) u_msb12 (
        .clk(clk), .rst(rst), .in(tb_in), .data(d_m12), .count(c_m12), .full(f_m12));
    shift_register #(.WIDTH(12), .MSB_FIRST(0)) u_lsb12 (
        .clk(clk), .rst(rst), .in(tb_in), .data(d_l12), .count(c_l12), .full(f_l12));
    shift_register #(.WIDTH(4), .MSB_FIRST(1)) u_msb4 (
        .clk(clk), .rst(rst), .in(tb_in), .data(d_m4), .count(c_m4), .full(f_m4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last w received bits placed by arrival order; unfilled slots are 0.
    function automatic logic [31:0] exp_data(input int w, input bit msb);
        logic [31:0] d;
        logic        b;
        d = '0;
        for (int k = 0; k < w; k++) begin
            b = (k < hist.size()) ? hist[hist.size() - 1 - k] : 1'b0;
            if (msb) d[k] = b;
            else     d[w - 1 - k] = b;
        end
        return d;
    endfunction

    function automatic int exp_count(input int w);
        return (hist.size() < w) ? hist.size() : w;
    endfunction

    task automatic step(input logic b);
        tb_in = b;
        @(posedge clk);
        if (rst === 1'b1) begin
            hist.push_back(b);
            if (hist.size() > 40) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        hist.delete();
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        tb_in = 1'b0;
        #3;
        n_cmp++;
        if (d_m12 !== 12'h000 || c_m12 !== 4'd0 || f_m12 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_m12: data=%h count=%0d full=%b, required 000/0/0", d_m12, c_m12, f_m12);
        end
        n_cmp++;
        if (d_l12 !== 12'h000 || c_l12 !== 4'd0 || f_l12 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_l12: data=%h count=%0d full=%b, required 000/0/0", d_l12, c_l12, f_l12);
        end
        n_cmp++;
        if (d_m4 !== 4'h0 || c_m4 !== 3'd0 || f_m4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_m4: data=%h count=%0d full=%b, required 0/0/0", d_m4, c_m4, f_m4);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_msb_pattern();
        logic [11:0] pat;
        logic [31:0] e;
        pat = 12'hACE;
        pulse_reset();
        for (int i = 11; i >= 0; i--) step(pat[i]);
        n_cmp++;
        if (d_m12 !== 12'hACE || c_m12 !== 4'd12 || f_m12 !== 1'b1) begin
            n_err++;
            $display("FAIL msb_ace: data=%h count=%0d full=%b, required ace/12/1", d_m12, c_m12, f_m12);
        end
        e = exp_data(12, 1'b0);
        n_cmp++;
        if (d_l12 !== e[11:0]) begin
            n_err++;
            $display("FAIL msb_ace_lsbdut: data=%h, required %h", d_l12, e[11:0]);
        end
        n_cmp++;
        if (d_m4 !== 4'hE || f_m4 !== 1'b1) begin
            n_err++;
            $display("FAIL msb_ace_w4: data=%h full=%b, required e/1", d_m4, f_m4);
        end
        step(1'b1);
        n_cmp++;
        if (d_m12 !== 12'h59D || c_m12 !== 4'd12 || f_m12 !== 1'b1) begin
            n_err++;
            $display("FAIL msb_overflow: data=%h count=%0d full=%b, required 59d/12/1", d_m12, c_m12, f_m12);
        end
        n_cmp++;
        if (d_m4 !== 4'hD || c_m4 !== 3'd4) begin
            n_err++;
            $display("FAIL msb_overflow_w4: data=%h count=%0d, required d/4", d_m4, c_m4);
        end
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        for (int i = 0; i < 5; i++) step(1'b1);
        rst = 1'b0;
        hist.delete();
        #1;
        n_cmp++;
        if (d_m12 !== 12'h000 || c_m12 !== 4'd0 || f_m12 !== 1'b0) begin
            n_err++;
            $display("FAIL async_clear: data=%h count=%0d full=%b, required 000/0/0", d_m12, c_m12, f_m12);
        end
        #1;
        rst = 1'b1;
        for (int i = 0; i < 11; i++) step(1'b0);
        n_cmp++;
        if (f_m12 !== 1'b0 || c_m12 !== 4'd11) begin
            n_err++;
            $display("FAIL restart_11: count=%0d full=%b, required 11/0", c_m12, f_m12);
        end
        step(1'b0);
        n_cmp++;
        if (d_m12 !== 12'h000 || c_m12 !== 4'd12 || f_m12 !== 1'b1) begin
            n_err++;
            $display("FAIL restart_12: data=%h count=%0d full=%b, required 000/12/1", d_m12, c_m12, f_m12);
        end
    endtask

    task automatic test_lsb_pattern();
        logic [11:0] pat;
        pat = 12'hACE;
        pulse_reset();
        for (int i = 0; i < 11; i++) step(pat[i]);
        n_cmp++;
        if (f_l12 !== 1'b0 || c_l12 !== 4'd11) begin
            n_err++;
            $display("FAIL lsb_11: count=%0d full=%b, required 11/0", c_l12, f_l12);
        end
        step(pat[11]);
        n_cmp++;
        if (d_l12 !== 12'hACE || c_l12 !== 4'd12 || f_l12 !== 1'b1) begin
            n_err++;
            $display("FAIL lsb_ace: data=%h count=%0d full=%b, required ace/12/1", d_l12, c_l12, f_l12);
        end
    endtask

    task automatic test_reset_hold();
        int bad;
        bad = 0;
        rst = 1'b0;
        hist.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (d_m12 !== 12'h000 || c_m12 !== 4'd0 || d_l12 !== 12'h000 || d_m4 !== 4'h0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_hold: %0d edges changed state, required 0", bad);
        end
        #2;
        rst = 1'b1;
    endtask

    task automatic test_width4();
        pulse_reset();
        step(1'b1);
        step(1'b0);
        step(1'b0);
        n_cmp++;
        if (f_m4 !== 1'b0 || c_m4 !== 3'd3) begin
            n_err++;
            $display("FAIL w4_3: count=%0d full=%b, required 3/0", c_m4, f_m4);
        end
        step(1'b1);
        n_cmp++;
        if (d_m4 !== 4'h9 || c_m4 !== 3'd4 || f_m4 !== 1'b1) begin
            n_err++;
            $display("FAIL w4_4: data=%h count=%0d full=%b, required 9/4/1", d_m4, c_m4, f_m4);
        end
    endtask

    task automatic test_x_input();
        logic [31:0] e;
        pulse_reset();
        step(1'b1);
        step(1'bx);
        e = exp_data(12, 1'b1);
        n_cmp++;
        if (d_m12 !== e[11:0] || c_m12 !== 4'd2 || f_m12 !== 1'b0) begin
            n_err++;
            $display("FAIL x_in: data=%b count=%0d full=%b, required %b/2/0", d_m12, c_m12, f_m12, e[11:0]);
        end
        for (int i = 0; i < 12; i++) step(1'b0);
    endtask

    task automatic test_random();
        logic [31:0] e;
        int          ec;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            step(1'($urandom_range(0, 1)));
            e  = exp_data(12, 1'b1);
            ec = exp_count(12);
            n_cmp++;
            if (d_m12 !== e[11:0] || c_m12 !== 4'(ec) || f_m12 !== (ec == 12)) begin
                n_err++;
                $display("FAIL rand_m12 #%0d: data=%h count=%0d full=%b, required %h/%0d/%b",
                         n, d_m12, c_m12, f_m12, e[11:0], ec, ec == 12);
            end
            e = exp_data(12, 1'b0);
            n_cmp++;
            if (d_l12 !== e[11:0] || c_l12 !== 4'(ec) || f_l12 !== (ec == 12)) begin
                n_err++;
                $display("FAIL rand_l12 #%0d: data=%h count=%0d full=%b, required %h/%0d/%b",
                         n, d_l12, c_l12, f_l12, e[11:0], ec, ec == 12);
            end
            e  = exp_data(4, 1'b1);
            ec = exp_count(4);
            n_cmp++;
            if (d_m4 !== e[3:0] || c_m4 !== 3'(ec) || f_m4 !== (ec == 4)) begin
                n_err++;
                $display("FAIL rand_m4 #%0d: data=%h count=%0d full=%b, required %h/%0d/%b",
                         n, d_m4, c_m4, f_m4, e[3:0], ec, ec == 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_pattern();
        test_mid_reset();
        test_lsb_pattern();
        test_reset_hold();
        test_width4();
        test_x_input();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
